// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the two-source UDP transmit arbiter.
//   MAX_UDP_PAYLOAD : largest UDP payload that fits in one Ethernet frame
//   tx_state_e      : arbiter FSM states
//   SRC0 / SRC1     : source indices, also the tx_sel encoding
//   tx_grant_t      : grant payload (selected source + latched length)
//   clamp_len       : limits a requested length to the payload maximum
package eth_tx_pkg;

  localparam int unsigned MAX_UDP_PAYLOAD = 1472;
  localparam int unsigned LEN_W           = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } tx_state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  typedef struct packed {
    logic             sel;
    logic [LEN_W-1:0] len;
  } tx_grant_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Request / grant bundle between the packet sources, the UDP transmitter and
// the arbiter.
//   req0/len0, req1/len1 : per-source packet ready level and payload length
//   eth_tx_done          : transmitter end-of-packet strobe
//   err_clr              : clears the sticky timeout flag
//   tx_en_pulse, tx_len, tx_sel : start strobe, length and data mux select
//   done0/done1          : per-source packet finished/aborted pulse
//   busy, timeout_err    : status
// slave = arbiter side, master = sources/transmitter side.
interface eth_tx_arbiter_if;
  import eth_tx_pkg::*;

  logic             req0;
  logic [LEN_W-1:0] len0;
  logic             req1;
  logic [LEN_W-1:0] len1;
  logic             eth_tx_done;
  logic             err_clr;
  logic             tx_en_pulse;
  logic [LEN_W-1:0] tx_len;
  logic             tx_sel;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  req0, len0, req1, len1, eth_tx_done, err_clr,
    output tx_en_pulse, tx_len, tx_sel, done0, done1, busy, timeout_err
  );

  modport master (
    output req0, len0, req1, len1, eth_tx_done, err_clr,
    input  tx_en_pulse, tx_len, tx_sel, done0, done1, busy, timeout_err
  );

endinterface

// File: rtl/eth_tx_timer.sv
// Loadable saturating down-counter used for both the inter-packet gap and the
// completion watchdog.
//   clk125M, udp_gmii_rst_n : clock, async active-low reset
//   load, load_val          : reload the count (has priority over en)
//   en                      : decrement, holding at zero
//   tc_c                    : count is zero (combinational)
module eth_tx_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk125M,
  input  logic             udp_gmii_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc_c
);

  logic [CNT_W-1:0] count;

  // Count register: reload wins, otherwise decrement and stick at zero.
  always_ff @(posedge clk125M or negedge udp_gmii_rst_n) begin
    if (!udp_gmii_rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin per-packet arbiter sharing one UDP transmit path between two
// sources. Latches the winner's (clamped) length, issues one start strobe,
// waits for completion with a watchdog, then holds off for an inter-packet gap.
//   clk125M, udp_gmii_rst_n : 125 MHz clock, async active-low reset
//   bus (slave)             : request, transmitter and status signals
module eth_tx_arbiter
  import eth_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned MAX_LEN        = MAX_UDP_PAYLOAD
) (
  input  logic           clk125M,
  input  logic           udp_gmii_rst_n,
  eth_tx_arbiter_if.slave bus
);

  localparam int unsigned CNT_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 1;
  localparam int unsigned WD_LOAD  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  tx_state_e        state;
  tx_state_e        state_nxt;
  logic             last_served;
  logic             vld0_c;
  logic             vld1_c;
  logic             grant_c;
  logic             grant_sel_c;
  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;
  logic             pkt_end_c;

  logic             tx_en_d;
  logic             done0_d;
  logic             done1_d;
  logic             busy_d;
  logic             err_d;
  logic             sel_d;
  logic [LEN_W-1:0] len_d;
  logic             last_d;

  // Zero-length requests are treated as absent; on a tie the source not
  // served last wins.
  assign vld0_c      = bus.req0 && (bus.len0 != '0);
  assign vld1_c      = bus.req1 && (bus.len1 != '0);
  assign grant_c     = vld0_c || vld1_c;
  assign grant_sel_c = vld1_c && (!vld0_c || (last_served == SRC0));

  // Completion wins over a watchdog expiry in the same cycle.
  assign pkt_end_c   = (state == WAIT_DONE) && (bus.eth_tx_done || tmr_tc);

  eth_tx_timer #(.CNT_W(CNT_W)) u_timer (
    .clk125M        (clk125M),
    .udp_gmii_rst_n (udp_gmii_rst_n),
    .load           (tmr_load),
    .load_val       (tmr_val),
    .en             (tmr_en),
    .tc_c           (tmr_tc)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk125M or negedge udp_gmii_rst_n) begin
    if (!udp_gmii_rst_n) begin
      state           <= IDLE;
      last_served     <= SRC1;
      bus.tx_en_pulse <= 1'b0;
      bus.tx_len      <= '0;
      bus.tx_sel      <= SRC0;
      bus.done0       <= 1'b0;
      bus.done1       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_served     <= last_d;
      bus.tx_en_pulse <= tx_en_d;
      bus.tx_len      <= len_d;
      bus.tx_sel      <= sel_d;
      bus.done0       <= done0_d;
      bus.done1       <= done1_d;
      bus.busy        <= busy_d;
      bus.timeout_err <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_c)   state_nxt = START;
      START:                    state_nxt = WAIT_DONE;
      WAIT_DONE: if (pkt_end_c) state_nxt = GAP;
      GAP:       if (tmr_tc)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and timer controls.
  always_comb begin
    tx_en_d  = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = (state_nxt != IDLE);
    sel_d    = bus.tx_sel;
    len_d    = bus.tx_len;
    last_d   = last_served;
    err_d    = bus.err_clr ? 1'b0 : bus.timeout_err;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = CNT_W'(WD_LOAD);
    case (state)
      IDLE: begin
        if (grant_c) begin
          sel_d  = grant_sel_c;
          len_d  = clamp_len(grant_sel_c ? bus.len1 : bus.len0, MAX_LEN_V);
          last_d = grant_sel_c;
        end
      end
      START: begin
        tx_en_d  = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(WD_LOAD);
      end
      WAIT_DONE: begin
        tmr_en = 1'b1;
        if (pkt_end_c) begin
          done0_d  = (bus.tx_sel == SRC0);
          done1_d  = (bus.tx_sel == SRC1);
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_LOAD);
          // Watchdog abort; a simultaneous err_clr loses.
          if (!bus.eth_tx_done) err_d = 1'b1;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
  import eth_tx_pkg::*;

  localparam int unsigned GAP  = 256;
  localparam int unsigned TMO  = 600;
  localparam logic [15:0] MAXL = 16'd1472;

  logic clk125M = 1'b0;
  logic udp_gmii_rst_n;
  eth_tx_arbiter_if bus();

  eth_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .MAX_LEN(1472)) dut (
    .clk125M        (clk125M),
    .udp_gmii_rst_n (udp_gmii_rst_n),
    .bus            (bus)
  );

  always #4 clk125M = ~clk125M;

  int        vecs = 0;
  int        errs = 0;
  int        cyc  = 0;
  bit        m_last;
  tx_grant_t exp_q[$];
  tx_grant_t sb_exp;

  always @(posedge clk125M) cyc <= cyc + 1;

  // Push the expected grant and advance the round-robin model.
  task automatic sb_push(input logic sel, input logic [15:0] len);
    tx_grant_t g;
    g.sel = sel;
    g.len = (len > MAXL) ? MAXL : len;
    exp_q.push_back(g);
    m_last = sel;
  endtask

  function automatic logic model_pick(input bit v0, input bit v1);
    return (v0 && v1) ? ~m_last : v1;
  endfunction

  // Scoreboard consumer: every start strobe must match the oldest expectation.
  always @(negedge clk125M) begin
    if (bus.tx_en_pulse === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_start: got sel=%0d len=%0d, required no start", bus.tx_sel, bus.tx_len);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({bus.tx_sel, bus.tx_len} !== sb_exp) begin
          errs++;
          $display("FAIL sb_grant: got sel=%0d len=%0d, required sel=%0d len=%0d",
                   bus.tx_sel, bus.tx_len, sb_exp.sel, sb_exp.len);
        end
      end
    end
  end

  task automatic wait_tx_en(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk125M);
      if (bus.tx_en_pulse === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int bound);
    bit idle = 1'b0;
    for (int i = 0; i < bound && !idle; i++) begin
      @(negedge clk125M);
      if (bus.busy === 1'b0) idle = 1'b1;
    end
    vecs++;
    if (!idle) begin errs++; $display("FAIL wait_idle: got busy=1, required 0 within %0d cycles", bound); end
  endtask

  task automatic pulse_done();
    bus.eth_tx_done = 1'b1;
    @(negedge clk125M);
    bus.eth_tx_done = 1'b0;
  endtask

  task automatic test_reset();
    udp_gmii_rst_n  = 1'b0;
    bus.req0 = 1'b0; bus.len0 = '0; bus.req1 = 1'b0; bus.len1 = '0;
    bus.eth_tx_done = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk125M);
    vecs++;
    if ({bus.tx_en_pulse, bus.tx_sel, bus.done0, bus.done1, bus.busy, bus.timeout_err, bus.tx_len} !== 22'd0) begin
      errs++;
      $display("FAIL reset_outputs: got en=%b sel=%b d0=%b d1=%b busy=%b err=%b len=%0d, required all 0",
               bus.tx_en_pulse, bus.tx_sel, bus.done0, bus.done1, bus.busy, bus.timeout_err, bus.tx_len);
    end
    udp_gmii_rst_n = 1'b1;
    m_last = 1'b1;
    @(negedge clk125M);
  endtask

  task automatic test_single();
    int d0 = 0, en = 0;
    bus.req0 = 1'b1; bus.len0 = 16'd1000;
    sb_push(model_pick(1, 0), 16'd1000);
    @(negedge clk125M);
    vecs++;
    if (bus.tx_sel !== 1'b0 || bus.tx_len !== 16'd1000 || bus.busy !== 1'b1 || bus.tx_en_pulse !== 1'b0) begin
      errs++;
      $display("FAIL single_grant: got sel=%0d len=%0d busy=%b en=%b, required 0 1000 1 0",
               bus.tx_sel, bus.tx_len, bus.busy, bus.tx_en_pulse);
    end
    @(negedge clk125M);
    vecs++;
    if (bus.tx_en_pulse !== 1'b1) begin errs++; $display("FAIL single_start_latency: got en=%b, required 1", bus.tx_en_pulse); end
    @(negedge clk125M);
    vecs++;
    if (bus.tx_en_pulse !== 1'b0) begin errs++; $display("FAIL single_pulse_width: got en=%b, required 0", bus.tx_en_pulse); end
    repeat (48) @(negedge clk125M);
    pulse_done();
    bus.req0 = 1'b0;
    vecs++;
    if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0) begin
      errs++; $display("FAIL single_done: got d0=%b d1=%b, required 1 0", bus.done0, bus.done1);
    end
    for (int i = 0; i < int'(GAP) - 1; i++) begin
      @(negedge clk125M);
      if (bus.done0 === 1'b1) d0++;
      if (bus.tx_en_pulse === 1'b1) en++;
    end
    vecs++;
    if (bus.busy !== 1'b1 || d0 != 0 || en != 0) begin
      errs++; $display("FAIL single_gap_hold: got busy=%b extra_done=%0d starts=%0d, required 1 0 0", bus.busy, d0, en);
    end
    @(negedge clk125M);
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_gap_end: got busy=%b, required 0", bus.busy); end
    vecs++;
    if (bus.tx_sel !== 1'b0 || bus.tx_len !== 16'd1000) begin
      errs++; $display("FAIL single_hold_sel_len: got sel=%0d len=%0d, required 0 1000", bus.tx_sel, bus.tx_len);
    end
  endtask

  task automatic test_alternate();
    int   dly[4] = '{0, 10, 0, 30};
    int   last_t = 0;
    logic pick;
    bit   seen;
    bus.req0 = 1'b1; bus.len0 = 16'd100;
    bus.req1 = 1'b1; bus.len1 = 16'd200;
    for (int p = 0; p < 4; p++) begin
      pick = model_pick(1, 1);
      sb_push(pick, pick ? 16'd200 : 16'd100);
      wait_tx_en(1000, seen);
      vecs++;
      if (!seen) begin errs++; $display("FAIL alt_start_%0d: got no start, required start", p); break; end
      if (p > 0) begin
        vecs++;
        if (cyc - last_t < int'(GAP) + 3) begin
          errs++; $display("FAIL alt_spacing_%0d: got %0d cycles, required >= %0d", p, cyc - last_t, GAP + 3);
        end
      end
      last_t = cyc;
      repeat (dly[p]) @(negedge clk125M);
      pulse_done();
      if (p == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      vecs++;
      if ({bus.done1, bus.done0} !== (pick ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL alt_done_%0d: got d1d0=%b%b, required src %0d", p, bus.done1, bus.done0, pick);
      end
    end
    wait_idle(400);
  endtask

  task automatic test_length();
    int  b = 0, e = 0;
    bit  seen;
    bus.req1 = 1'b1; bus.len1 = 16'd4000;
    sb_push(model_pick(0, 1), 16'd4000);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL len_clamp_start: got no start, required start"); end
    vecs++;
    if (bus.tx_len !== MAXL) begin errs++; $display("FAIL len_clamp: got %0d, required %0d", bus.tx_len, MAXL); end
    pulse_done();
    bus.req1 = 1'b0;
    vecs++;
    if (bus.done1 !== 1'b1) begin errs++; $display("FAIL len_done1: got %b, required 1", bus.done1); end
    wait_idle(400);
    bus.req0 = 1'b1; bus.len0 = 16'd0;
    repeat (50) begin
      @(negedge clk125M);
      if (bus.busy === 1'b1) b++;
      if (bus.tx_en_pulse === 1'b1) e++;
    end
    bus.req0 = 1'b0;
    vecs++;
    if (b != 0 || e != 0) begin errs++; $display("FAIL len_zero: got busy_cycles=%0d starts=%0d, required 0 0", b, e); end
  endtask

  task automatic test_watchdog();
    int at = -1;
    bit seen;
    bus.req0 = 1'b1; bus.len0 = 16'd500;
    sb_push(model_pick(1, 0), 16'd500);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL wd_start: got no start, required start"); end
    // err_clr coincides with the abort cycle; the set must win.
    for (int i = 1; i <= int'(TMO) + 5 && at < 0; i++) begin
      bus.err_clr = (i == int'(TMO));
      @(negedge clk125M);
      if (bus.done0 === 1'b1) at = i;
    end
    bus.err_clr = 1'b0;
    bus.req0 = 1'b0;
    vecs++;
    if (at != int'(TMO)) begin errs++; $display("FAIL wd_latency: got %0d, required %0d", at, TMO); end
    vecs++;
    if (bus.timeout_err !== 1'b1) begin errs++; $display("FAIL wd_err_set: got %b, required 1", bus.timeout_err); end
    wait_idle(400);
    bus.req1 = 1'b1; bus.len1 = 16'd64;
    sb_push(model_pick(0, 1), 16'd64);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL wd_next_served: got no start, required start"); end
    pulse_done();
    bus.req1 = 1'b0;
    vecs++;
    if (bus.done1 !== 1'b1 || bus.timeout_err !== 1'b1) begin
      errs++; $display("FAIL wd_sticky: got d1=%b err=%b, required 1 1", bus.done1, bus.timeout_err);
    end
    wait_idle(400);
    bus.err_clr = 1'b1;
    @(negedge clk125M);
    bus.err_clr = 1'b0;
    vecs++;
    if (bus.timeout_err !== 1'b0) begin errs++; $display("FAIL wd_err_clr: got %b, required 0", bus.timeout_err); end
    // Completion on the final watchdog cycle is a normal completion.
    bus.req0 = 1'b1; bus.len0 = 16'd32;
    sb_push(model_pick(1, 0), 16'd32);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL wd_edge_start: got no start, required start"); end
    repeat (TMO - 1) @(negedge clk125M);
    pulse_done();
    bus.req0 = 1'b0;
    vecs++;
    if (bus.done0 !== 1'b1 || bus.timeout_err !== 1'b0) begin
      errs++; $display("FAIL wd_edge_done: got d0=%b err=%b, required 1 0", bus.done0, bus.timeout_err);
    end
    wait_idle(400);
  endtask

  task automatic test_spurious();
    int d = 0;
    bit seen;
    pulse_done();
    vecs++;
    if ({bus.done0, bus.done1, bus.busy, bus.tx_en_pulse} !== 4'b0000) begin
      errs++; $display("FAIL spur_idle: got d0=%b d1=%b busy=%b en=%b, required 0 0 0 0",
                       bus.done0, bus.done1, bus.busy, bus.tx_en_pulse);
    end
    bus.req1 = 1'b1; bus.len1 = 16'd700;
    sb_push(model_pick(0, 1), 16'd700);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL spur_start: got no start, required start"); end
    pulse_done();
    bus.req1 = 1'b0;
    vecs++;
    if (bus.done1 !== 1'b1) begin errs++; $display("FAIL spur_done1: got %b, required 1", bus.done1); end
    repeat (9) @(negedge clk125M);
    bus.eth_tx_done = 1'b1;
    for (int i = 0; i < int'(GAP) - 10; i++) begin
      @(negedge clk125M);
      bus.eth_tx_done = 1'b0;
      if (bus.done0 === 1'b1 || bus.done1 === 1'b1) d++;
    end
    vecs++;
    if (d != 0 || bus.busy !== 1'b1) begin
      errs++; $display("FAIL spur_gap: got done_pulses=%0d busy=%b, required 0 1", d, bus.busy);
    end
    @(negedge clk125M);
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL spur_gap_len: got busy=%b, required 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.req0 = 1'b1; bus.len0 = 16'd300;
    sb_push(model_pick(1, 0), 16'd300);
    wait_tx_en(20, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL rst_pre_start: got no start, required start"); end
    repeat (5) @(negedge clk125M);
    bus.req1 = 1'b1; bus.len1 = 16'd400;
    udp_gmii_rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.tx_en_pulse, bus.tx_sel, bus.done0, bus.done1, bus.busy, bus.timeout_err, bus.tx_len} !== 22'd0) begin
      errs++;
      $display("FAIL rst_mid_outputs: got en=%b sel=%b d0=%b d1=%b busy=%b err=%b len=%0d, required all 0",
               bus.tx_en_pulse, bus.tx_sel, bus.done0, bus.done1, bus.busy, bus.timeout_err, bus.tx_len);
    end
    repeat (2) @(negedge clk125M);
    udp_gmii_rst_n = 1'b1;
    m_last = 1'b1;
    sb_push(model_pick(1, 1), 16'd300);
    wait_tx_en(10, seen);
    vecs++;
    if (!seen || bus.tx_sel !== 1'b0) begin
      errs++; $display("FAIL rst_first_grant: got seen=%b sel=%b, required 1 0", seen, bus.tx_sel);
    end
    pulse_done();
    bus.req0 = 1'b0;
    vecs++;
    if (bus.done0 !== 1'b1) begin errs++; $display("FAIL rst_done0: got %b, required 1", bus.done0); end
    sb_push(model_pick(0, 1), 16'd400);
    wait_tx_en(400, seen);
    vecs++;
    if (!seen) begin errs++; $display("FAIL rst_second_start: got no start, required start"); end
    pulse_done();
    bus.req1 = 1'b0;
    vecs++;
    if (bus.done1 !== 1'b1) begin errs++; $display("FAIL rst_done1: got %b, required 1", bus.done1); end
    wait_idle(400);
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_length();
    test_watchdog();
    test_spurious();
    test_reset_mid();
    vecs++;
    if (exp_q.size() != 0) begin
      errs++; $display("FAIL sb_leftover: got %0d pending grants, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
